round_sequencer: RTL
====================

Name: round_sequencer

Overview:
- Game-flow controller that runs one blackjack round end to end.
- Sequence: clears both hands, deals the opening four cards, runs the player turn, then runs the dealer's hit/stand policy, then resolves the outcome.
- Drives the per-hand draw strobes into the two hand controllers, gated by the deck's card-ready flag.
- Consumes the resulting hand sums and card counts; produces the top-level gameState and turnIndicator signals.

Parameters:
- DEALER_STAND_AT, 17: dealer stands when dealer sum >= this value.
- BLACKJACK, 21: bust threshold; sum > BLACKJACK is a bust.
- MAX_CARDS, 5: hand capacity; no draw is issued to a hand holding MAX_CARDS cards.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous, active-low reset; the polarity and synchronicity are fixed.
- i_start  in  1  one-cycle pulse that begins a new round; ignored outside IDLE and DONE.
- i_playerInputReady  in  1  one-cycle strobe: i_playerCommand is valid this cycle.
- i_playerCommand  in  gameCommand  COMMAND_HIT or COMMAND_STAND; any other value is ignored.
- i_cardValid  in  1  deck has a card presented this cycle.
- i_playerHandSum, i_dealerHandSum  in  hand (6b unsigned)  current hand totals.
- i_playerCardCount, i_dealerCardCount  in  3  cards currently held.
- o_handClear  out  1  one-cycle pulse that empties both hands.
- o_drawPlayer, o_drawDealer  out  1  one-cycle draw strobes; never high together.
- o_gameState  out  gameState  GAME_IDLE, GAME_DEAL, GAME_PLAYER_TURN, GAME_DEALER_TURN, GAME_PLAYER_WIN, GAME_DEALER_WIN or GAME_PUSH.
- o_turn  out  turnIndicator  TURN_NONE, TURN_PLAYER or TURN_DEALER.

Behaviour:
- Reset (i_reset==0 at a clock edge):
  - FSM goes to IDLE and the deal index goes to 0.
  - o_gameState=GAME_IDLE, o_turn=TURN_NONE.
  - o_handClear, o_drawPlayer and o_drawDealer are 0.
  - Reset mid-round aborts the round immediately, including any pending draw. No strobe is emitted in the reset cycle.
- All outputs are registered.
- Draw handshake:
  - In a *_REQ state the sequencer asserts the strobe for exactly one cycle, in the first cycle with i_cardValid==1. While i_cardValid==0 it holds in REQ.
  - After a strobe the FSM always passes through one *_SETTLE cycle before reading sums or counts. Hand inputs are valid from the cycle after the strobe.
- States and transitions:
  - IDLE: on i_start -> CLEAR.
  - CLEAR: o_handClear=1 for one cycle; deal index=0 -> DEAL_REQ.
  - DEAL_REQ: draw target by index 0..3 = player, dealer, player, dealer -> DEAL_SETTLE.
  - DEAL_SETTLE: index++. If index<4 -> DEAL_REQ. Otherwise, player sum==BLACKJACK -> DEALER_DECIDE, else -> PLAYER_WAIT.
  - PLAYER_WAIT: on i_playerInputReady:
    - HIT with player count<MAX_CARDS -> PLAYER_REQ.
    - HIT at MAX_CARDS is ignored and the FSM stays in PLAYER_WAIT.
    - STAND -> DEALER_DECIDE.
    - i_start is ignored here.
  - PLAYER_REQ -> PLAYER_SETTLE. Then, in priority order:
    - sum>BLACKJACK -> DONE with GAME_DEALER_WIN.
    - sum==BLACKJACK or count==MAX_CARDS -> DEALER_DECIDE.
    - otherwise -> PLAYER_WAIT.
  - DEALER_DECIDE: dealer sum<DEALER_STAND_AT and count<MAX_CARDS -> DEALER_REQ; otherwise -> RESOLVE.
  - DEALER_REQ -> DEALER_SETTLE -> DEALER_DECIDE.
  - RESOLVE (one cycle):
    - dealer>BLACKJACK -> GAME_PLAYER_WIN.
    - player>dealer -> GAME_PLAYER_WIN.
    - player<dealer -> GAME_DEALER_WIN.
    - equal -> GAME_PUSH.
    - Then -> DONE.
  - DONE: result held; on i_start -> CLEAR.
- Output mapping by state:
  - CLEAR and DEAL_*: GAME_DEAL / TURN_NONE.
  - PLAYER_*: GAME_PLAYER_TURN / TURN_PLAYER.
  - DEALER_* and RESOLVE: GAME_DEALER_TURN / TURN_DEALER.
  - IDLE and DONE: TURN_NONE.
- Comparisons are unsigned, 6-bit.
- If i_start and i_playerInputReady arrive in the same cycle, the state rules decide which one is honoured.

Decomposition:
- Shared package / headers:
  - hand typedef (6-bit).
  - gameState, turnIndicator and gameCommand enums (extended with the values above).
  - Defaults for DEALER_STAND_AT, BLACKJACK and MAX_CARDS.
- One sub-module, dealer_ai (combinational):
  - Inputs: dealer sum and count.
  - Output: gameCommand, COMMAND_HIT or COMMAND_STAND.
  - DEALER_DECIDE uses it.

Test Plan:
- Deal flow: reset, i_start, i_cardValid=1 held, deck values 10,7,9,10 -> o_handClear 1 cycle; strobes player,dealer,player,dealer each 2 cycles apart; then GAME_PLAYER_TURN, player sum 19.
- Player stand and dealer win: player 18, STAND; dealer 10+6 -> one o_drawDealer; dealer draws 4 -> 20 -> RESOLVE -> GAME_DEALER_WIN, TURN_NONE.
- Player bust: player 15, HIT, card 10 -> 25 -> GAME_DEALER_WIN; no o_drawDealer issued.
- Stalled deck and limits:
  - i_cardValid low 5 cycles during DEAL_REQ -> no strobe and state held; the strobe fires on the first valid cycle.
  - HIT with player count 5 -> no strobe.
- Natural and push: dealt player 21 -> straight to GAME_DEALER_TURN; dealer 21 -> GAME_PUSH.
- Reset mid dealer turn: i_reset=0 during DEALER_REQ -> next cycle GAME_IDLE, all strobes 0, i_start restarts cleanly.

Source files
------------

// File: rtl/round_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : round_sequencer_pkg
// Description : Shared types and default limits for the blackjack round
//               sequencer: hand totals, game state, turn indicator, player
//               command encoding and the sequencer FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package round_sequencer_pkg;

  // Hand total, 6-bit unsigned
  typedef logic [5:0] hand;

  typedef enum logic [2:0] {
    GAME_IDLE        = 3'd0,
    GAME_DEAL        = 3'd1,
    GAME_PLAYER_TURN = 3'd2,
    GAME_DEALER_TURN = 3'd3,
    GAME_PLAYER_WIN  = 3'd4,
    GAME_DEALER_WIN  = 3'd5,
    GAME_PUSH        = 3'd6
  } gameState;

  typedef enum logic [1:0] {
    TURN_NONE   = 2'd0,
    TURN_PLAYER = 2'd1,
    TURN_DEALER = 2'd2
  } turnIndicator;

  typedef enum logic [1:0] {
    COMMAND_NONE  = 2'd0,
    COMMAND_HIT   = 2'd1,
    COMMAND_STAND = 2'd2
  } gameCommand;

  // Sequencer FSM states. *_SETTLE is the cycle in which the registered draw
  // strobe is visible; hand inputs are read no earlier than the cycle after.
  typedef enum logic [3:0] {
    S_IDLE          = 4'd0,
    S_CLEAR         = 4'd1,
    S_DEAL_REQ      = 4'd2,
    S_DEAL_SETTLE   = 4'd3,
    S_PLAYER_WAIT   = 4'd4,
    S_PLAYER_REQ    = 4'd5,
    S_PLAYER_SETTLE = 4'd6,
    S_PLAYER_CHECK  = 4'd7,
    S_DEALER_DECIDE = 4'd8,
    S_DEALER_REQ    = 4'd9,
    S_DEALER_SETTLE = 4'd10,
    S_RESOLVE       = 4'd11,
    S_DONE          = 4'd12
  } seqState;

  localparam int unsigned DEALER_STAND_AT_DEFAULT = 17;
  localparam int unsigned BLACKJACK_DEFAULT       = 21;
  localparam int unsigned MAX_CARDS_DEFAULT       = 5;

endpackage
`default_nettype wire

// File: rtl/round_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : round_sequencer_if
// Description : Bundle between the round sequencer and its environment.
//               slave  : sequencer side (takes i_*, drives o_*)
//               master : environment side (drives i_*, takes o_*)
//   i_start, i_playerInputReady, i_playerCommand : round / player control
//   i_cardValid                                  : deck card ready
//   i_playerHandSum, i_dealerHandSum             : hand totals
//   i_playerCardCount, i_dealerCardCount         : cards held
//   o_handClear, o_drawPlayer, o_drawDealer      : hand strobes
//   o_gameState, o_turn                          : round status
// Revision    : 1.0 - initial release
// ============================================================================
interface round_sequencer_if;
  import round_sequencer_pkg::*;

  logic         i_start;
  logic         i_playerInputReady;
  gameCommand   i_playerCommand;
  logic         i_cardValid;
  hand          i_playerHandSum;
  hand          i_dealerHandSum;
  logic [2:0]   i_playerCardCount;
  logic [2:0]   i_dealerCardCount;
  logic         o_handClear;
  logic         o_drawPlayer;
  logic         o_drawDealer;
  gameState     o_gameState;
  turnIndicator o_turn;

  modport slave (
    input  i_start, i_playerInputReady, i_playerCommand, i_cardValid,
    input  i_playerHandSum, i_dealerHandSum, i_playerCardCount, i_dealerCardCount,
    output o_handClear, o_drawPlayer, o_drawDealer, o_gameState, o_turn
  );

  modport master (
    output i_start, i_playerInputReady, i_playerCommand, i_cardValid,
    output i_playerHandSum, i_dealerHandSum, i_playerCardCount, i_dealerCardCount,
    input  o_handClear, o_drawPlayer, o_drawDealer, o_gameState, o_turn
  );

endinterface
`default_nettype wire

// File: rtl/round_sequencer_dealer_ai.sv
`default_nettype none
// ============================================================================
// Module      : round_sequencer_dealer_ai
// Description : Combinational dealer policy: hit while below the stand
//               threshold and the hand still has room, otherwise stand.
//   i_dealerSum   : dealer hand total
//   i_dealerCount : dealer cards held
//   o_command     : COMMAND_HIT or COMMAND_STAND
// Revision    : 1.0 - initial release
// ============================================================================
module round_sequencer_dealer_ai
  import round_sequencer_pkg::*;
#(
  parameter int unsigned DEALER_STAND_AT = DEALER_STAND_AT_DEFAULT,
  parameter int unsigned MAX_CARDS       = MAX_CARDS_DEFAULT
) (
  input  hand        i_dealerSum,
  input  logic [2:0] i_dealerCount,
  output gameCommand o_command
);

  localparam hand        c_STAND_AT  = hand'(DEALER_STAND_AT);
  localparam logic [2:0] c_MAX_CARDS = 3'(MAX_CARDS);

  always_comb begin
    o_command = COMMAND_STAND;
    if ((i_dealerSum < c_STAND_AT) && (i_dealerCount < c_MAX_CARDS)) begin
      o_command = COMMAND_HIT;
    end
  end

endmodule
`default_nettype wire

// File: rtl/round_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : round_sequencer
// Description : Runs one blackjack round: clear hands, deal four cards,
//               player turn, dealer policy, resolve. All outputs registered.
//   i_clk   : system clock
//   i_reset : synchronous active-low reset
//   bus     : round_sequencer_if.slave (control, deck, hand and status)
// Revision    : 1.0 - initial release
// ============================================================================
module round_sequencer
  import round_sequencer_pkg::*;
#(
  parameter int unsigned DEALER_STAND_AT = DEALER_STAND_AT_DEFAULT,
  parameter int unsigned BLACKJACK       = BLACKJACK_DEFAULT,
  parameter int unsigned MAX_CARDS       = MAX_CARDS_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_reset,
  round_sequencer_if.slave  bus
);

  localparam hand        c_BLACKJACK = hand'(BLACKJACK);
  localparam logic [2:0] c_MAX_CARDS = 3'(MAX_CARDS);

  seqState      r_state, w_stateNext;
  logic [2:0]   r_dealIdx, w_dealIdxNext;
  gameState     r_result, w_resultNext;
  logic         r_handClear, r_drawPlayer, r_drawDealer;
  logic         w_handClear, w_drawPlayer, w_drawDealer;
  gameState     r_gameState, w_gameState;
  turnIndicator r_turn, w_turn;
  gameCommand   w_dealerCmd;

  round_sequencer_dealer_ai #(
    .DEALER_STAND_AT (DEALER_STAND_AT),
    .MAX_CARDS       (MAX_CARDS)
  ) u_dealer_ai (
    .i_dealerSum   (bus.i_dealerHandSum),
    .i_dealerCount (bus.i_dealerCardCount),
    .o_command     (w_dealerCmd)
  );

  always_comb begin
    w_stateNext   = r_state;
    w_dealIdxNext = r_dealIdx;
    w_resultNext  = r_result;
    w_drawPlayer  = 1'b0;
    w_drawDealer  = 1'b0;

    case (r_state)
      S_IDLE:
        if (bus.i_start) w_stateNext = S_CLEAR;
      S_CLEAR: begin
        w_dealIdxNext = 3'd0;
        w_stateNext   = S_DEAL_REQ;
      end
      S_DEAL_REQ:
        if (bus.i_cardValid) begin
          // Even deal slots go to the player, odd slots to the dealer
          w_drawPlayer = ~r_dealIdx[0];
          w_drawDealer = r_dealIdx[0];
          w_stateNext  = S_DEAL_SETTLE;
        end
      S_DEAL_SETTLE: begin
        w_dealIdxNext = r_dealIdx + 3'd1;
        // Last slot is the dealer's, so the player total is already stable here
        if (w_dealIdxNext < 3'd4)                  w_stateNext = S_DEAL_REQ;
        else if (bus.i_playerHandSum == c_BLACKJACK) w_stateNext = S_DEALER_DECIDE;
        else                                         w_stateNext = S_PLAYER_WAIT;
      end
      S_PLAYER_WAIT:
        if (bus.i_playerInputReady) begin
          if ((bus.i_playerCommand == COMMAND_HIT) &&
              (bus.i_playerCardCount < c_MAX_CARDS)) begin
            w_stateNext = S_PLAYER_REQ;
          end else if (bus.i_playerCommand == COMMAND_STAND) begin
            w_stateNext = S_DEALER_DECIDE;
          end
        end
      S_PLAYER_REQ:
        if (bus.i_cardValid) begin
          w_drawPlayer = 1'b1;
          w_stateNext  = S_PLAYER_SETTLE;
        end
      // Strobe is on the bus this cycle; the new total is read one cycle later
      S_PLAYER_SETTLE:
        w_stateNext = S_PLAYER_CHECK;
      S_PLAYER_CHECK:
        if (bus.i_playerHandSum > c_BLACKJACK) begin
          w_resultNext = GAME_DEALER_WIN;
          w_stateNext  = S_DONE;
        end else if ((bus.i_playerHandSum == c_BLACKJACK) ||
                     (bus.i_playerCardCount >= c_MAX_CARDS)) begin
          w_stateNext = S_DEALER_DECIDE;
        end else begin
          w_stateNext = S_PLAYER_WAIT;
        end
      S_DEALER_DECIDE:
        w_stateNext = (w_dealerCmd == COMMAND_HIT) ? S_DEALER_REQ : S_RESOLVE;
      S_DEALER_REQ:
        if (bus.i_cardValid) begin
          w_drawDealer = 1'b1;
          w_stateNext  = S_DEALER_SETTLE;
        end
      S_DEALER_SETTLE:
        w_stateNext = S_DEALER_DECIDE;
      S_RESOLVE: begin
        if (bus.i_dealerHandSum > c_BLACKJACK)                  w_resultNext = GAME_PLAYER_WIN;
        else if (bus.i_playerHandSum > bus.i_dealerHandSum)     w_resultNext = GAME_PLAYER_WIN;
        else if (bus.i_playerHandSum < bus.i_dealerHandSum)     w_resultNext = GAME_DEALER_WIN;
        else                                                    w_resultNext = GAME_PUSH;
        w_stateNext = S_DONE;
      end
      S_DONE:
        if (bus.i_start) w_stateNext = S_CLEAR;
      default:
        w_stateNext = S_IDLE;
    endcase

    // Status outputs are decoded from the next state so that, once
    // registered, they line up with the state the FSM is actually in.
    w_handClear = (w_stateNext == S_CLEAR);
    w_gameState = GAME_IDLE;
    w_turn      = TURN_NONE;
    case (w_stateNext)
      S_CLEAR, S_DEAL_REQ, S_DEAL_SETTLE:
        w_gameState = GAME_DEAL;
      S_PLAYER_WAIT, S_PLAYER_REQ, S_PLAYER_SETTLE, S_PLAYER_CHECK: begin
        w_gameState = GAME_PLAYER_TURN;
        w_turn      = TURN_PLAYER;
      end
      S_DEALER_DECIDE, S_DEALER_REQ, S_DEALER_SETTLE, S_RESOLVE: begin
        w_gameState = GAME_DEALER_TURN;
        w_turn      = TURN_DEALER;
      end
      S_DONE:
        w_gameState = w_resultNext;
      default: begin
        w_gameState = GAME_IDLE;
        w_turn      = TURN_NONE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state      <= S_IDLE;
      r_dealIdx    <= 3'd0;
      r_result     <= GAME_IDLE;
      r_handClear  <= 1'b0;
      r_drawPlayer <= 1'b0;
      r_drawDealer <= 1'b0;
      r_gameState  <= GAME_IDLE;
      r_turn       <= TURN_NONE;
    end else begin
      r_state      <= w_stateNext;
      r_dealIdx    <= w_dealIdxNext;
      r_result     <= w_resultNext;
      r_handClear  <= w_handClear;
      r_drawPlayer <= w_drawPlayer;
      r_drawDealer <= w_drawDealer;
      r_gameState  <= w_gameState;
      r_turn       <= w_turn;
    end
  end

  assign bus.o_handClear  = r_handClear;
  assign bus.o_drawPlayer = r_drawPlayer;
  assign bus.o_drawDealer = r_drawDealer;
  assign bus.o_gameState  = r_gameState;
  assign bus.o_turn       = r_turn;

endmodule
`default_nettype wire
